// File: rtl/exec_sequencer.sv
// Instruction sequencer for the 4-bit SimpleMicroprocessor.
// Fetches 16-bit instructions over a req/ack handshake. It then steps the phase
// bus through FETCH, DECODE, READ and EXEC, and drives the register-file
// addresses, the ALU opcode and the write enable. Every output comes straight
// from a flop.
module exec_sequencer #(
  parameter int         PC_W    = 4,
  parameter logic [3:0] S_IDLE   = 4'b0000,
  parameter logic [3:0] S_FETCH  = 4'b0001,
  parameter logic [3:0] S_DECODE = 4'b0010,
  parameter logic [3:0] S_READ   = 4'b0100,
  parameter logic [3:0] S_EXEC   = 4'b1110,
  parameter logic [3:0] S_HALT   = 4'b1111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [3:0]      pst,
  output logic [3:0]      Rd1,
  output logic [3:0]      Rd2,
  output logic [3:0]      Wr,
  output logic [3:0]      alu_op,
  output logic            Reg_Write,
  input  logic            overflow,
  input  logic            underflow,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            flow_err
);

  typedef enum logic [3:0] {
    ST_IDLE   = S_IDLE,
    ST_FETCH  = S_FETCH,
    ST_DECODE = S_DECODE,
    ST_READ   = S_READ,
    ST_EXEC   = S_EXEC,
    ST_HALT   = S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     instr_q, instr_d;
  logic            req_d, rw_d, halted_d, ferr_d;
  logic [3:0]      rd1_d, rd2_d, wr_d, op_d;
  logic [PC_W-1:0] pc_d;

  // Opcodes 0x1..0xD write back; 0x0 (NOP), 0xE (compare) and 0xF (HALT) do not.
  function automatic logic is_writeback(input logic [3:0] op);
    return (op != 4'h0) && (op < 4'hE);
  endfunction

  assign pst       = state_q;
  assign imem_addr = pc;

  // Next-state and next-output decode. Each register holds its value unless its phase updates it.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    req_d    = imem_req;
    rw_d     = 1'b0;
    rd1_d    = Rd1;
    rd2_d    = Rd2;
    wr_d     = Wr;
    op_d     = alu_op;
    pc_d     = pc;
    ferr_d   = flow_err;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
          ferr_d  = 1'b0;
        end
      end
      ST_FETCH: begin
        // imem_data is trusted only in the cycle it is acknowledged.
        if (imem_ack) begin
          instr_d = imem_data;
          req_d   = 1'b0;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        op_d  = instr_q[15:12];
        wr_d  = instr_q[11:8];
        rd1_d = instr_q[7:4];
        rd2_d = instr_q[3:0];
        if (instr_q[15:12] == 4'hF) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // Enable is raised on entry to EXEC, so it is high only while pst shows EXEC.
        state_d = ST_EXEC;
        rw_d    = is_writeback(instr_q[15:12]);
      end
      ST_EXEC: begin
        if (Reg_Write && (overflow || underflow)) begin
          ferr_d = 1'b1;
        end
        pc_d = pc + {{(PC_W-1){1'b0}}, 1'b1};
        if (run) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (!run) begin
          state_d = ST_IDLE;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
    halted_d = (state_d == ST_HALT);
  end

  // State and output registers. Reset clears them at once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      imem_req  <= 1'b0;
      Reg_Write <= 1'b0;
      Rd1       <= '0;
      Rd2       <= '0;
      Wr        <= '0;
      alu_op    <= '0;
      pc        <= '0;
      halted    <= 1'b0;
      flow_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      imem_req  <= req_d;
      Reg_Write <= rw_d;
      Rd1       <= rd1_d;
      Rd2       <= rd2_d;
      Wr        <= wr_d;
      alu_op    <= op_d;
      pc        <= pc_d;
      halted    <= halted_d;
      flow_err  <= ferr_d;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Testbench for exec_sequencer. The bench drives directed programs. A
// behavioural model, written as one sequential instruction loop, predicts
// every output. Literal checks pin the key cycles.
`timescale 1ns/1ps
module tb_exec_sequencer;
  localparam logic [3:0] P_IDLE = 4'h0, P_FETCH = 4'h1, P_DEC = 4'h2,
                         P_READ = 4'h4, P_EXEC = 4'hE, P_HALT = 4'hF;

  logic        clk, rst, run, imem_req, imem_ack, overflow, underflow;
  logic        Reg_Write, halted, flow_err;
  logic [3:0]  imem_addr, pc, pst, Rd1, Rd2, Wr, alu_op;
  logic [15:0] imem_data;
  logic [15:0] mem [16];
  int          ack_dly = 0;
  bit          spur = 0;
  int          n_tests = 0, n_fail = 0;
  int          n_rw, n_fetch;

  // Model expectations
  logic [3:0]  e_pst, e_rd1, e_rd2, e_wr, e_op, e_pc;
  logic        e_req, e_rw, e_halt, e_ferr;

  exec_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .pst(pst), .Rd1(Rd1), .Rd2(Rd2), .Wr(Wr), .alu_op(alu_op), .Reg_Write(Reg_Write),
    .overflow(overflow), .underflow(underflow), .pc(pc), .halted(halted), .flow_err(flow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  task automatic m_reset();
    e_pst = P_IDLE; e_req = 1'b0; e_rw = 1'b0; e_halt = 1'b0; e_ferr = 1'b0;
    e_rd1 = '0; e_rd2 = '0; e_wr = '0; e_op = '0; e_pc = '0;
  endtask

  task automatic tick(output bit ab);
    @(posedge clk or posedge rst);
    ab = rst;
  endtask

  task automatic model_run();
    bit ab;
    logic [15:0] ins;
    forever begin
      do begin tick(ab); if (ab) return; end while (!run);
      e_ferr = 1'b0;
      forever begin
        e_pst = P_FETCH; e_req = 1'b1;
        do begin tick(ab); if (ab) return; end while (!imem_ack);
        ins = imem_data; e_pst = P_DEC; e_req = 1'b0;
        tick(ab); if (ab) return;
        e_op = ins[15:12]; e_wr = ins[11:8]; e_rd1 = ins[7:4]; e_rd2 = ins[3:0];
        if (ins[15:12] == 4'hF) begin
          e_pst = P_HALT; e_halt = 1'b1;
          do begin tick(ab); if (ab) return; end while (run);
          e_pst = P_IDLE; e_halt = 1'b0; e_pc = '0;
          break;
        end
        e_pst = P_READ;
        tick(ab); if (ab) return;
        e_pst = P_EXEC;
        e_rw = (ins[15:12] >= 4'h1) && (ins[15:12] <= 4'hD);
        tick(ab); if (ab) return;
        if (e_rw && (overflow || underflow)) e_ferr = 1'b1;
        e_rw = 1'b0;
        e_pc = e_pc + 4'd1;
        if (!run) begin
          e_pst = P_IDLE;
          break;
        end
      end
    end
  endtask

  initial begin
    forever begin
      m_reset();
      wait (rst);
      wait (!rst);
      model_run();
    end
  end

  // Compare process: every output against the model, every cycle
  initial begin
    forever begin
      @(negedge clk);
      chk("pst", 16'(pst), 16'(e_pst));
      chk("imem_req", 16'(imem_req), 16'(e_req));
      chk("imem_addr", 16'(imem_addr), 16'(e_pc));
      chk("pc", 16'(pc), 16'(e_pc));
      chk("Reg_Write", 16'(Reg_Write), 16'(e_rw));
      chk("halted", 16'(halted), 16'(e_halt));
      chk("flow_err", 16'(flow_err), 16'(e_ferr));
      chk("Rd1", 16'(Rd1), 16'(e_rd1));
      chk("Rd2", 16'(Rd2), 16'(e_rd2));
      chk("Wr", 16'(Wr), 16'(e_wr));
      chk("alu_op", 16'(alu_op), 16'(e_op));
    end
  end

  // Instruction memory responder with a programmable ack delay
  initial begin
    int cnt;
    cnt = 0; imem_ack = 1'b0; imem_data = 16'h0BAD;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        imem_ack = 1'b0; cnt = 0; imem_data = 16'h0BAD;
      end else if (imem_req && !imem_ack) begin
        if (cnt >= ack_dly) begin
          imem_ack = 1'b1; imem_data = mem[imem_addr]; cnt = 0;
        end else begin
          cnt++; imem_data = 16'h0BAD;
        end
      end else begin
        imem_ack  = spur && (pst == P_READ);
        imem_data = imem_ack ? 16'hF000 : 16'h0BAD;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv();
    @(posedge clk); #3;
  endtask

  task automatic wait_pst(input logic [3:0] code, input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (Reg_Write) n_rw++;
      if (pst == P_FETCH && imem_req) n_fetch++;
      if (pst == code) return;
    end
    n_tests++; n_fail++;
    $display("FAIL %s: timeout waiting for pst=%0h, got %0h", nm, code, pst);
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1;
    drv(); drv();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; overflow = 1'b0; underflow = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pst", 16'(pst), 16'h0);
    chk("rst_req", 16'(imem_req), 16'h0);
    chk("rst_rw", 16'(Reg_Write), 16'h0);
    chk("rst_pc", 16'(pc), 16'h0);
    chk("rst_ferr", 16'(flow_err), 16'h0);
    drv(); rst = 1'b0;

    // T1: 0x1321 with immediate ack, then HALT
    mem[0] = 16'h1321; mem[1] = 16'hF000;
    drv(); run = 1'b1;
    @(negedge clk); chk("t1_idle", 16'(pst), 16'h0);
    @(negedge clk); chk("t1_fetch", 16'(pst), 16'h1); chk("t1_req", 16'(imem_req), 16'h1);
    @(negedge clk); chk("t1_dec", 16'(pst), 16'h2); chk("t1_req_fall", 16'(imem_req), 16'h0);
    @(negedge clk); chk("t1_read", 16'(pst), 16'h4);
    chk("t1_wr", 16'(Wr), 16'h3); chk("t1_rd1", 16'(Rd1), 16'h2);
    chk("t1_rd2", 16'(Rd2), 16'h1); chk("t1_op", 16'(alu_op), 16'h1);
    chk("t1_rw_read", 16'(Reg_Write), 16'h0);
    @(negedge clk); chk("t1_exec", 16'(pst), 16'hE); chk("t1_rw_exec", 16'(Reg_Write), 16'h1);
    chk("t1_model_exec", 16'(e_pst), 16'hE);
    @(negedge clk); chk("t1_next", 16'(pst), 16'h1); chk("t1_rw_after", 16'(Reg_Write), 16'h0);
    chk("t1_pc", 16'(pc), 16'h1);
    wait_pst(P_HALT, 10, "t1_halt");
    chk("t1_halted", 16'(halted), 16'h1); chk("t1_halt_pc", 16'(pc), 16'h1);
    run = 1'b0;
    wait_pst(P_IDLE, 5, "t1_idle2");
    chk("t1_pc_clr", 16'(pc), 16'h0);

    // T2: ack delayed 3 cycles; run dropped mid-instruction
    mem[0] = 16'h2567; ack_dly = 3; n_fetch = 0; n_rw = 0;
    drv(); run = 1'b1;
    wait_pst(P_DEC, 20, "t2_dec");
    chk("t2_fetch_cycles", 16'(n_fetch), 16'd4);
    run = 1'b0;
    wait_pst(P_IDLE, 10, "t2_idle");
    chk("t2_rw_count", 16'(n_rw), 16'd1);
    chk("t2_pc", 16'(pc), 16'h1); chk("t2_op", 16'(alu_op), 16'h2);
    ack_dly = 0;

    // T3: NOP, compare, HALT with flags high and stray acks
    do_reset();
    mem[0] = 16'h0000; mem[1] = 16'hE456; mem[2] = 16'hF000;
    overflow = 1'b1; underflow = 1'b1; spur = 1'b1; n_rw = 0;
    drv(); run = 1'b1;
    wait_pst(P_HALT, 30, "t3_halt");
    chk("t3_rw_count", 16'(n_rw), 16'd0);
    chk("t3_halted", 16'(halted), 16'h1); chk("t3_pc", 16'(pc), 16'h2);
    chk("t3_ferr", 16'(flow_err), 16'h0);
    run = 1'b0;
    wait_pst(P_IDLE, 5, "t3_idle");
    chk("t3_pc_clr", 16'(pc), 16'h0);
    overflow = 1'b0; underflow = 1'b0; spur = 1'b0;

    // T4: overflow on a writeback sets the sticky flag until the next start
    mem[0] = 16'h3123; mem[1] = 16'h1456; mem[2] = 16'hF000;
    drv(); run = 1'b1;
    wait_pst(P_EXEC, 20, "t4_exec");
    overflow = 1'b1;
    @(negedge clk); overflow = 1'b0;
    chk("t4_ferr_set", 16'(flow_err), 16'h1);
    wait_pst(P_HALT, 20, "t4_halt");
    chk("t4_ferr_hold", 16'(flow_err), 16'h1);
    run = 1'b0;
    wait_pst(P_IDLE, 5, "t4_idle");
    chk("t4_ferr_idle", 16'(flow_err), 16'h1);
    drv(); run = 1'b1;
    wait_pst(P_FETCH, 5, "t4_fetch");
    chk("t4_ferr_clr", 16'(flow_err), 16'h0);
    wait_pst(P_EXEC, 20, "t4_exec0");
    wait_pst(P_EXEC, 20, "t4_exec1");
    underflow = 1'b1;
    @(negedge clk); underflow = 1'b0;
    chk("t4_ferr_unf", 16'(flow_err), 16'h1);
    wait_pst(P_HALT, 20, "t4_halt2");
    run = 1'b0;
    wait_pst(P_IDLE, 5, "t4_idle2");

    // T5: 16 NOPs, pc wraps and fetch continues at 0
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    drv(); run = 1'b1;
    for (int i = 0; i < 16; i++) wait_pst(P_EXEC, 10, "t5_exec");
    @(negedge clk);
    chk("t5_wrap_pst", 16'(pst), 16'h1); chk("t5_wrap_addr", 16'(imem_addr), 16'h0);
    chk("t5_wrap_pc", 16'(pc), 16'h0);
    run = 1'b0;
    wait_pst(P_IDLE, 10, "t5_idle");
    chk("t5_pc", 16'(pc), 16'h1);

    // T6: asynchronous reset in READ, in EXEC, and with a fetch pending
    mem[0] = 16'h1321; mem[1] = 16'h1321;
    drv(); run = 1'b1;
    wait_pst(P_READ, 10, "t6_read");
    #1 rst = 1'b1;
    #1 chk("t6a_pst", 16'(pst), 16'h0); chk("t6a_rw", 16'(Reg_Write), 16'h0);
    chk("t6a_req", 16'(imem_req), 16'h0); chk("t6a_pc", 16'(pc), 16'h0);
    run = 1'b0; drv(); drv(); rst = 1'b0;

    drv(); run = 1'b1;
    wait_pst(P_EXEC, 10, "t6_exec");
    chk("t6b_rw_pre", 16'(Reg_Write), 16'h1);
    #1 rst = 1'b1;
    #1 chk("t6b_pst", 16'(pst), 16'h0); chk("t6b_rw", 16'(Reg_Write), 16'h0);
    run = 1'b0; drv(); drv(); rst = 1'b0;

    drv(); run = 1'b1;
    wait_pst(P_EXEC, 10, "t6_exec2");
    ack_dly = 10;
    wait_pst(P_FETCH, 5, "t6_fetch");
    chk("t6c_req_pre", 16'(imem_req), 16'h1); chk("t6c_pc_pre", 16'(pc), 16'h1);
    #1 rst = 1'b1;
    #1 chk("t6c_pst", 16'(pst), 16'h0); chk("t6c_req", 16'(imem_req), 16'h0);
    chk("t6c_pc", 16'(pc), 16'h0);
    run = 1'b0; drv(); drv(); rst = 1'b0; ack_dly = 0;

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Instruction sequencer for the 4-bit SimpleMicroprocessor.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake, decodes them into register-file addresses and an ALU opcode, and steps the shared phase bus `pst` through FETCH, DECODE, READ and EXEC.
- Issues `Reg_Write` only in EXEC, so it is the initiating end of the register-file interface: it drives the read addresses, write address, write enable and the phase the register file gates on.
- Also tracks the program counter, HALT, and suppressed-write (overflow/underflow) reporting.

## Interface
Parameters:
- PC_W, 4, program counter / instruction memory address width (16 instructions)
- S_IDLE, 4'b0000, phase code: idle
- S_FETCH, 4'b0001, phase code: instruction fetch
- S_DECODE, 4'b0010, phase code: decode, register addresses issued
- S_READ, 4'b0100, phase code: synchronous register read in flight
- S_EXEC, 4'b1110, phase code: execute/writeback (fixed; the register file writes only in this code)
- S_HALT, 4'b1111, phase code: halted

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run  in  1  level: 1 = execute program, 0 = stop after current instruction
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  one-cycle acknowledge; imem_data valid in the same cycle
- imem_data  in  16  instruction: [15:12] opcode, [11:8] Wr, [7:4] Rd1, [3:0] Rd2
- pst  out  4  current phase code
- Rd1  out  4  register read address 1
- Rd2  out  4  register read address 2
- Wr  out  4  register write address
- alu_op  out  4  opcode forwarded to the ALU
- Reg_Write  out  1  write enable, high only while pst==S_EXEC
- overflow  in  1  ALU overflow, sampled in EXEC
- underflow  in  1  ALU underflow, sampled in EXEC
- pc  out  PC_W  program counter
- halted  out  1  1 while pst==S_HALT
- flow_err  out  1  sticky: a writeback was suppressed by overflow/underflow

## Operation
Reset values:
- All outputs 0; pst = S_IDLE (4'b0000).
- Instruction latch cleared.

Opcode classes:
- 0x0 NOP: no writeback.
- 0x1–0xD ALU with writeback.
- 0xE ALU without writeback (compare).
- 0xF HALT.

State machine:
- IDLE: `run`=1 → FETCH; clears flow_err on that transition.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch imem_data → DECODE. Waits indefinitely for ack.
- DECODE: register Rd1, Rd2, Wr and alu_op from the latch; deassert imem_req → READ. Opcode 0xF → HALT instead, with pc unchanged.
- READ: one cycle while the register file performs its synchronous read → EXEC.
- EXEC: Reg_Write=1 iff opcode in 0x1–0xD.
  - Wr==0 still raises Reg_Write; the register file drops the write.
  - If Reg_Write=1 and (overflow|underflow), set flow_err.
  - pc <= pc+1, wrapping from 15 to 0.
  - Next state: FETCH if `run`=1, else IDLE.
- HALT: halted=1; all outputs hold. `run`=0 → IDLE with pc cleared to 0.

Output rules:
- Rd1, Rd2, Wr and alu_op hold their value from DECODE until the next DECODE.
- NOP traverses DECODE/READ/EXEC with Reg_Write=0.

## Timing
- All outputs are registered; pst changes only on clk rising edges.
- Fetch with ack in the first FETCH cycle: 4 cycles per instruction (FETCH, DECODE, READ, EXEC). Each cycle of ack delay adds one FETCH cycle.
- Reg_Write is high for exactly one cycle per writeback instruction, coincident with pst==S_EXEC. It is never high in any other phase.
- imem_req:
  - rises in the first FETCH cycle and falls in the cycle after ack;
  - an ack while imem_req=0 is ignored;
  - imem_data is sampled only in the ack cycle.
- `run` is sampled only in IDLE, EXEC and HALT. Deasserting it mid-instruction never aborts that instruction.
- Asynchronous rst mid-operation: pst → S_IDLE and imem_req/Reg_Write → 0 immediately, without waiting for a clock edge. Any in-flight fetch is abandoned.
- flow_err is updated at the end of the EXEC cycle and holds until the next IDLE→FETCH transition or reset.

## Test plan
- Reset then run=1, imem returns 0x1321 at addr 0 with immediate ack → pst sequence 1,2,4,E; Wr=3, Rd1=2, Rd2=1, alu_op=1; Reg_Write high only in the E cycle; pc=1 afterwards.
- Ack delayed 3 cycles → FETCH lasts 4 cycles with imem_req high throughout; decode, read and exec timing are otherwise unchanged.
- Program NOP, 0xE456, 0xF000 → Reg_Write never asserts; after HALT: pst=F, halted=1, pc=2. run=0 → IDLE with pc=0.
- Writeback instruction with overflow=1 during EXEC → flow_err=1 and stays set through later instructions; the next IDLE→FETCH clears it.
- Run 16 NOPs from pc=0 → pc wraps from 15 to 0 and fetch continues at addr 0.
- Assert rst during READ, and separately with imem_req high in FETCH → pst=0, Reg_Write=0, imem_req=0 and pc=0 without a clock edge.
